// File: rtl/rv32_d_dx_pipe_if.sv
// Decode->execute handshake bundle: upstream entry, downstream head, writeback and flush.
// The slave modport is the pipe register's view; master is the driver/consumer side.
interface rv32_d_dx_pipe_if #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64,
  parameter int RADDR_W   = 5
) ();
  logic                 flush_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [PAYLOAD_W-1:0] in_payload_i;
  logic [RADDR_W-1:0]   in_rs1_addr_i;
  logic [RADDR_W-1:0]   in_rs2_addr_i;
  logic [XLEN-1:0]      in_rs1_data_i;
  logic [XLEN-1:0]      in_rs2_data_i;
  logic                 wb_en_i;
  logic [RADDR_W-1:0]   wb_addr_i;
  logic [XLEN-1:0]      wb_data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [PAYLOAD_W-1:0] out_payload_o;
  logic [XLEN-1:0]      out_rs1_data_o;
  logic [XLEN-1:0]      out_rs2_data_o;

  modport slave (
    input  flush_i, in_valid_i, in_payload_i, in_rs1_addr_i, in_rs2_addr_i,
           in_rs1_data_i, in_rs2_data_i, wb_en_i, wb_addr_i, wb_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_payload_o, out_rs1_data_o, out_rs2_data_o
  );

  modport master (
    output flush_i, in_valid_i, in_payload_i, in_rs1_addr_i, in_rs2_addr_i,
           in_rs1_data_i, in_rs2_data_i, wb_en_i, wb_addr_i, wb_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_payload_o, out_rs1_data_o, out_rs2_data_o
  );
endinterface

// File: rtl/rv32_d_dx_pipe.sv
// Decode/execute pipeline register with writeback operand refresh and write-through capture.
// Define DX_PIPE_SKID_EN to add a skid slot and a registered in_ready_o.
module rv32_d_dx_pipe #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64,
  parameter int RADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  rv32_d_dx_pipe_if.slave   bus
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] pl;
    logic [RADDR_W-1:0]   rs1_addr;
    logic [RADDR_W-1:0]   rs2_addr;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
  } slot_t;

`ifdef DX_PIPE_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1} state_e;
`endif

  // Address 0 is hardwired zero in the register file, so it never takes writeback data.
  function automatic slot_t refresh(input slot_t s, input logic wb_en,
                                    input logic [RADDR_W-1:0] wb_addr,
                                    input logic [XLEN-1:0] wb_data);
    slot_t r;
    r = s;
    if (wb_en && (wb_addr != {RADDR_W{1'b0}}) && (wb_addr == s.rs1_addr)) begin
      r.rs1_data = wb_data;
    end else begin
      r.rs1_data = s.rs1_data;
    end
    if (wb_en && (wb_addr != {RADDR_W{1'b0}}) && (wb_addr == s.rs2_addr)) begin
      r.rs2_data = wb_data;
    end else begin
      r.rs2_data = s.rs2_data;
    end
    return r;
  endfunction

  state_e state_q, state_d;
  slot_t  main_q, main_d;
  slot_t  in_slot_s, in_cap_s, main_ref_s;
  logic   accept_s, pop_s, in_ready_s;
`ifdef DX_PIPE_SKID_EN
  slot_t  skid_q, skid_d, skid_ref_s;
  logic   in_ready_q, in_ready_d;
  assign in_ready_s = in_ready_q;
`else
  assign in_ready_s = (state_q == ST_EMPTY) || bus.out_ready_i;
`endif

  // Next-state and slot data selection.
  always_comb begin
    in_slot_s  = '{pl: bus.in_payload_i, rs1_addr: bus.in_rs1_addr_i, rs2_addr: bus.in_rs2_addr_i,
                   rs1_data: bus.in_rs1_data_i, rs2_data: bus.in_rs2_data_i};
    in_cap_s   = refresh(in_slot_s, bus.wb_en_i, bus.wb_addr_i, bus.wb_data_i);
    main_ref_s = refresh(main_q, bus.wb_en_i, bus.wb_addr_i, bus.wb_data_i);
    accept_s   = bus.in_valid_i && in_ready_s;
    pop_s      = (state_q != ST_EMPTY) && bus.out_ready_i;
    state_d    = state_q;
    main_d     = (state_q != ST_EMPTY) ? main_ref_s : main_q;
`ifdef DX_PIPE_SKID_EN
    skid_ref_s = refresh(skid_q, bus.wb_en_i, bus.wb_addr_i, bus.wb_data_i);
    skid_d     = (state_q == ST_TWO) ? skid_ref_s : skid_q;
`endif
    if (bus.flush_i) begin
      state_d = ST_EMPTY;
      main_d  = '0;
`ifdef DX_PIPE_SKID_EN
      skid_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_d  = in_cap_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && pop_s) begin
            main_d  = in_cap_s;
            state_d = ST_ONE;
          end else if (accept_s) begin
`ifdef DX_PIPE_SKID_EN
            skid_d  = in_cap_s;
            state_d = ST_TWO;
`else
            state_d = ST_ONE;
`endif
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
`ifdef DX_PIPE_SKID_EN
        ST_TWO: begin
          if (pop_s) begin
            main_d  = skid_ref_s;
            state_d = ST_ONE;
          end else begin
            state_d = ST_TWO;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
`ifdef DX_PIPE_SKID_EN
    in_ready_d = (state_d != ST_TWO);
`endif
  end

  // State and slot registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
`ifdef DX_PIPE_SKID_EN
      skid_q     <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
`ifdef DX_PIPE_SKID_EN
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

  assign bus.in_ready_o     = in_ready_s;
  assign bus.out_valid_o    = (state_q != ST_EMPTY);
  assign bus.out_payload_o  = main_q.pl;
  assign bus.out_rs1_data_o = main_q.rs1_data;
  assign bus.out_rs2_data_o = main_q.rs2_data;

endmodule

// File: tb/tb_rv32_d_dx_pipe.sv
// Scoreboard bench for rv32_d_dx_pipe: a queue model of held entries is refreshed by writebacks
// and popped by an independent monitor on each downstream handshake.
module tb_rv32_d_dx_pipe;
  logic clk;
  logic rst_n;

  rv32_d_dx_pipe_if #(.XLEN(32), .PAYLOAD_W(64), .RADDR_W(5)) ifc ();

  rv32_d_dx_pipe #(.XLEN(32), .PAYLOAD_W(64), .RADDR_W(5)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (ifc)
  );

  typedef struct {
    logic [63:0] pl;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] d1;
    logic [31:0] d2;
  } ent_t;

`ifdef DX_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  ent_t mq[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // A register-file write to a nonzero matching address supersedes the operand value.
  function automatic ent_t apply_wb(input ent_t e, input logic we, input logic [4:0] wa,
                                    input logic [31:0] wd);
    ent_t r;
    r = e;
    if (we && wa != 5'd0 && wa == e.a1) r.d1 = wd;
    if (we && wa != 5'd0 && wa == e.a2) r.d2 = wd;
    return r;
  endfunction

  task automatic cycle(input logic iv, input logic [63:0] pl, input logic [4:0] a1,
                       input logic [31:0] d1, input logic [4:0] a2, input logic [31:0] d2,
                       input logic ordy, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic fl);
    ent_t e;
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    ifc.in_valid_i = iv;    ifc.in_payload_i = pl;
    ifc.in_rs1_addr_i = a1; ifc.in_rs1_data_i = d1;
    ifc.in_rs2_addr_i = a2; ifc.in_rs2_data_i = d2;
    ifc.out_ready_i = ordy; ifc.wb_en_i = we; ifc.wb_addr_i = wa; ifc.wb_data_i = wd;
    ifc.flush_i = fl;
    #1;
    if (CAP == 2) exp_rdy = (mq.size() < 2);
    else          exp_rdy = (mq.size() == 0) || ordy;
    chk("in_ready", {63'd0, ifc.in_ready_o}, {63'd0, exp_rdy});
    chk("out_valid", {63'd0, ifc.out_valid_o}, {63'd0, mq.size() != 0});
    acc = iv && exp_rdy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      foreach (mq[i]) mq[i] = apply_wb(mq[i], we, wa, wd);
      if (acc) begin
        e = '{pl: pl, a1: a1, a2: a2, d1: d1, d2: d2};
        mq.push_back(apply_wb(e, we, wa, wd));
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 64'd0, 5'd0, 32'd0, 5'd0, 32'd0, ordy, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic push(input logic [63:0] pl, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] a2, input logic [31:0] d2, input logic ordy);
    cycle(1'b1, pl, a1, d1, a2, d2, ordy, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Monitor: every downstream handshake retires the oldest modelled entry.
  always @(negedge clk) begin
    ent_t e;
    #2;
    if (rst_n && ifc.out_valid_o && ifc.out_ready_i && !ifc.flush_i) begin
      if (mq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_underflow: got out_valid 1 expected no entry");
      end else begin
        e = mq.pop_front();
        chk("out_payload", ifc.out_payload_o, e.pl);
        chk("out_rs1", {32'd0, ifc.out_rs1_data_o}, {32'd0, e.d1});
        chk("out_rs2", {32'd0, ifc.out_rs2_data_o}, {32'd0, e.d2});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ifc.in_valid_i = 1'b0; ifc.in_payload_i = 64'd0;
    ifc.in_rs1_addr_i = 5'd0; ifc.in_rs1_data_i = 32'd0;
    ifc.in_rs2_addr_i = 5'd0; ifc.in_rs2_data_i = 32'd0;
    ifc.out_ready_i = 1'b0; ifc.wb_en_i = 1'b0; ifc.wb_addr_i = 5'd0; ifc.wb_data_i = 32'd0;
    ifc.flush_i = 1'b0;
    #12;
    chk("rst_out_valid", {63'd0, ifc.out_valid_o}, 64'd0);
    chk("rst_in_ready", {63'd0, ifc.in_ready_o}, 64'd1);
    chk("rst_payload", ifc.out_payload_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic transfer, one-cycle latency.
    push(64'h1234, 5'd3, 32'hA, 5'd0, 32'd0, 1'b1);
    chk("basic_valid", {63'd0, ifc.out_valid_o}, 64'd1);
    chk("basic_payload", ifc.out_payload_o, 64'h1234);
    chk("basic_rs1", {32'd0, ifc.out_rs1_data_o}, 64'hA);
    idle(1'b1);

    // Stalled entry refreshed by a matching writeback; address-0 entry is not.
    push(64'h55, 5'd1, 32'h1, 5'd7, 32'h5, 1'b0);
    cycle(1'b0, 64'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd7, 32'hBEEF, 1'b0);
    chk("refresh_rs2", {32'd0, ifc.out_rs2_data_o}, 64'hBEEF);
    idle(1'b1);
    push(64'h66, 5'd0, 32'h3, 5'd0, 32'h5, 1'b0);
    cycle(1'b0, 64'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'hBEEF, 1'b0);
    chk("zero_no_refresh", {32'd0, ifc.out_rs2_data_o}, 64'h5);
    idle(1'b1);

    // Write-through capture on accept.
    cycle(1'b1, 64'h77, 5'd9, 32'h1, 5'd2, 32'h2, 1'b1, 1'b1, 5'd9, 32'h77, 1'b0);
    chk("writethrough_rs1", {32'd0, ifc.out_rs1_data_o}, 64'h77);
    idle(1'b1);

`ifdef DX_PIPE_SKID_EN
    // Skid fill: in_ready drops after the second entry, then drains in order.
    push(64'hA, 5'd1, 32'h11, 5'd2, 32'h12, 1'b0);
    push(64'hB, 5'd3, 32'h21, 5'd4, 32'h22, 1'b0);
    chk("skid_full_ready", {63'd0, ifc.in_ready_o}, 64'd0);
    idle(1'b1);
    chk("skid_ready_back", {63'd0, ifc.in_ready_o}, 64'd1);
    idle(1'b1);
    push(64'hC, 5'd1, 32'h31, 5'd2, 32'h32, 1'b0);
`endif
    // Flush with an incoming entry drops everything and zeroes the outputs.
    push(64'hD, 5'd5, 32'h41, 5'd6, 32'h42, 1'b0);
    cycle(1'b1, 64'hE, 5'd1, 32'h51, 5'd2, 32'h52, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("flush_valid", {63'd0, ifc.out_valid_o}, 64'd0);
    chk("flush_payload", ifc.out_payload_o, 64'd0);
    chk("flush_rs1", {32'd0, ifc.out_rs1_data_o}, 64'd0);
    chk("flush_rs2", {32'd0, ifc.out_rs2_data_o}, 64'd0);
    idle(1'b1);

    // Asynchronous reset mid-cycle with entries held.
    push(64'hF1, 5'd1, 32'h61, 5'd2, 32'h62, 1'b0);
    push(64'hF2, 5'd3, 32'h71, 5'd4, 32'h72, 1'b0);
    @(negedge clk);
    ifc.in_valid_i = 1'b0; ifc.out_ready_i = 1'b0; ifc.wb_en_i = 1'b0; ifc.flush_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, ifc.out_valid_o}, 64'd0);
    chk("async_rst_ready", {63'd0, ifc.in_ready_o}, 64'd1);
    chk("async_rst_payload", ifc.out_payload_o, 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with writebacks on a small register window to force hits.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1, {$urandom, $urandom},
            5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drained", {32'd0, 32'(mq.size())}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32_d_dx_pipe.md
RV32_D_DX_PIPE -- requirements
Module: rv32_d_dx_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand data width.
REQ-002 Parameter PAYLOAD_W, default 64, opaque decoded-control/PC/immediate bundle width.
REQ-003 Parameter RADDR_W, default 5, register address width.
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 flush_i  input  1  discard all held entries.
REQ-007 in_valid_i / in_ready_o  input / output  1 / 1  upstream handshake.
REQ-008 in_payload_i  input  PAYLOAD_W  decoded bundle.
REQ-009 in_rs1_addr_i, in_rs2_addr_i  input  RADDR_W  source register addresses.
REQ-010 in_rs1_data_i, in_rs2_data_i  input  XLEN  register file read data.
REQ-011 wb_en_i, wb_addr_i, wb_data_i  input  1 / RADDR_W / XLEN  writeback port, same as register file write.
REQ-012 out_valid_o / out_ready_i  output / input  1 / 1  downstream handshake.
REQ-013 out_payload_o, out_rs1_data_o, out_rs2_data_o  output  PAYLOAD_W / XLEN / XLEN  head entry fields.

Function
REQ-014 Transfer: accept = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i.
REQ-015 Latency: entry accepted at edge N appears on outputs with out_valid_o=1 after edge N.
REQ-016 Storage: main slot drives outputs; optional skid slot (Configuration); each slot holds payload, rs1/rs2 address, rs1/rs2 data, valid.
REQ-017 States EMPTY, ONE, TWO (TWO only with skid); out_valid_o = (state != EMPTY).
REQ-018 EMPTY: accept -> ONE, main loads input.
REQ-019 ONE: accept&&pop -> ONE, main loads input; accept&&!pop -> TWO, skid loads input; pop&&!accept -> EMPTY; neither -> hold.
REQ-020 TWO: pop -> ONE, main loads skid; !pop -> hold; accept impossible since in_ready_o=0.
REQ-021 Stall: with out_ready_i=0 all held fields stay constant except operand refresh (REQ-022).
REQ-022 Operand refresh: each cycle, any held valid entry whose rsN_addr equals wb_addr_i, with wb_en_i=1 and wb_addr_i!=0, loads wb_data_i into its rsN_data at the edge; applies to both slots and both operands independently.
REQ-023 Write-through capture: entry accepted in a cycle where wb_en_i=1, wb_addr_i!=0, wb_addr_i==in_rsN_addr_i captures wb_data_i instead of in_rsN_data_i.
REQ-024 Address 0 never refreshed nor written through; its data is captured as presented.
REQ-025 Entry moving skid->main in the same cycle as a matching writeback takes wb_data_i.
REQ-026 Flush: flush_i=1 at an edge -> state EMPTY, all stored fields zero, accept and pop in that cycle ignored (incoming entry dropped); out_valid_o=0 after edge.
REQ-027 out_payload_o/out_rsN_data_o hold zero whenever state is EMPTY after reset or flush; after a pop to EMPTY they hold last contents (don't-care to consumer).

Reset
REQ-028 rst_n_i low asynchronously forces state EMPTY, all slot fields zero, out_valid_o=0.
REQ-029 During and after reset in_ready_o=1; reset mid-transfer drops all held entries with no partial output.

Configuration
REQ-030 Macro DX_PIPE_SKID_EN defined: skid slot present, three states, in_ready_o is a register output = (next state != TWO), no combinational path out_ready_i -> in_ready_o.
REQ-031 DX_PIPE_SKID_EN undefined: no skid slot, states EMPTY/ONE only, in_ready_o = !out_valid_o || out_ready_i (combinational); REQ-019 accept&&!pop from ONE cannot occur.

Verification
REQ-032 Reset, then in_valid_i=1 payload 0x1234, rs1_addr=3 data 0xA, out_ready_i=1 -> next cycle out_valid_o=1, out_payload_o=0x1234, out_rs1_data_o=0xA; in_ready_o=1 throughout.
REQ-033 SKID_EN: out_ready_i=0, push entries A,B -> state TWO, in_ready_o=0 after second edge; out_ready_i=1 -> A then B popped in order, in_ready_o=1 again one cycle after A's pop.
REQ-034 Stalled entry rs2_addr=7 data 0x5; wb_en_i=1 addr 7 data 0xBEEF -> out_rs2_data_o=0xBEEF next cycle; same with addr 0 -> unchanged.
REQ-035 Accept with in_rs1_addr_i=9 data 0x1 while wb_en_i=1 addr 9 data 0x77 -> out_rs1_data_o=0x77.
REQ-036 State TWO, flush_i=1 with in_valid_i=1 -> out_valid_o=0, outputs zero, new entry not delivered.
REQ-037 rst_n_i pulsed low mid-cycle with two entries held -> out_valid_o=0 immediately, in_ready_o=1 without waiting for a clock edge.
